// File: rtl/seq_det_prog_if.sv
// Configuration, serial-data and status signals of the programmable pattern detector.
// The control side uses the master modport and the detector uses the slave modport.
interface seq_det_prog_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) ();
    logic               din;
    logic               din_vld;
    logic               cfg_load;
    logic [MAX_LEN-1:0] pattern;
    logic [LEN_W-1:0]   pat_len;
    logic               overlap;
    logic               cnt_clr;
    logic               armed;
    logic               match;
    logic [CNT_W-1:0]   match_cnt;
    logic               cnt_sat;

    modport master (
        output din, din_vld, cfg_load, pattern, pat_len, overlap, cnt_clr,
        input  armed, match, match_cnt, cnt_sat
    );

    modport slave (
        input  din, din_vld, cfg_load, pattern, pat_len, overlap, cnt_clr,
        output armed, match, match_cnt, cnt_sat
    );
endinterface

// File: rtl/seq_det_prog.sv
// Runtime-programmable serial pattern detector with overlap control, a din-valid
// qualifier and a saturating match counter. All outputs are registered.
module seq_det_prog #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int CNT_W   = 8
) (
    input logic            clk,
    input logic            rstn,
    seq_det_prog_if.slave  bus
);
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_FULL = {CNT_W{1'b1}};

    logic [MAX_LEN-1:0] pat_q,  pat_d;
    logic [LEN_W-1:0]   len_q,  len_d;
    logic               ovl_q,  ovl_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic               armed_q, armed_d;
    logic               match_q, match_d;
    logic [CNT_W-1:0]   cnt_q,  cnt_d;
    logic               sat_q,  sat_d;

    logic               sample_s;
    logic [MAX_LEN-1:0] hist_shift_s;
    logic [LEN_W-1:0]   fill_inc_s;
    logic [MAX_LEN-1:0] len_mask_s;
    logic               hit_s;

    // Next-state logic: config capture, history shift, hit detection and counter.
    always_comb begin
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        armed_d = armed_q;
        cnt_d   = cnt_q;

        sample_s     = armed_q & bus.din_vld & ~bus.cfg_load;
        hist_shift_s = {hist_q[MAX_LEN-2:0], bus.din};
        if (fill_q == LEN_MAX) begin
            fill_inc_s = fill_q;
        end else begin
            fill_inc_s = fill_q + LEN_W'(1);
        end

        for (int i = 0; i < MAX_LEN; i++) begin
            len_mask_s[i] = (LEN_W'(i) < len_q);
        end

        // Compare only the low len bits of the post-shift history.
        hit_s = sample_s & (fill_inc_s >= len_q) &
                (((hist_shift_s ^ pat_q) & len_mask_s) == {MAX_LEN{1'b0}});

        if (bus.cfg_load) begin
            pat_d   = bus.pattern;
            len_d   = bus.pat_len;
            ovl_d   = bus.overlap;
            hist_d  = {MAX_LEN{1'b0}};
            fill_d  = {LEN_W{1'b0}};
            armed_d = (bus.pat_len != {LEN_W{1'b0}}) && (bus.pat_len <= LEN_MAX);
        end else if (sample_s) begin
            hist_d = hist_shift_s;
            if (hit_s && !ovl_q) begin
                fill_d = {LEN_W{1'b0}};
            end else begin
                fill_d = fill_inc_s;
            end
        end else begin
            hist_d = hist_q;
        end

        if (bus.cnt_clr) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (hit_s && (cnt_q != CNT_FULL)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end

        match_d = hit_s;
        sat_d   = (cnt_d == CNT_FULL);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pat_q   <= {MAX_LEN{1'b0}};
            len_q   <= {LEN_W{1'b0}};
            ovl_q   <= 1'b0;
            hist_q  <= {MAX_LEN{1'b0}};
            fill_q  <= {LEN_W{1'b0}};
            armed_q <= 1'b0;
            match_q <= 1'b0;
            cnt_q   <= {CNT_W{1'b0}};
            sat_q   <= 1'b0;
        end else begin
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            armed_q <= armed_d;
            match_q <= match_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    assign bus.armed     = armed_q;
    assign bus.match     = match_q;
    assign bus.match_cnt = cnt_q;
    assign bus.cnt_sat   = sat_q;
endmodule
